// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the P6 fetch stage.
// Holds reset/fetch-window defaults, the nop word, exception codes,
// the PC increment and the jal/jalr link offset.
package fetch_stage_pkg;

  // Default fetch window and reset vector
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
  localparam logic [31:0] IM_LAST_DEF  = 32'h0000_6FFC;

  // Bubble inserted into IF/ID
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Sequential fetch step and link value offset (PC of delay slot + 4)
  localparam logic [31:0] PC_INC   = 32'd4;
  localparam logic [31:0] LINK_OFS = 32'd8;

  // Exception codes carried down the pipe
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // IF/ID pipeline register contents
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
  } ifid_t;

  // Address-error-on-load check for a fetch address: misaligned or
  // outside the instruction memory window [base, last].
  function automatic logic fetch_addr_bad(input logic [31:0] pc,
                                          input logic [31:0] base,
                                          input logic [31:0] last);
    return (pc[1:0] != 2'b00) || (pc < base) || (pc > last);
  endfunction

endpackage

// File: rtl/fetch_stage_f_pc.sv
// Program counter register and next-PC mux.
// Stall freezes the PC; otherwise a D-stage redirect wins over the
// sequential +4 step. The target is used as-is, even when misaligned.
module f_pc
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        npc_sel,
  input  logic [31:0] npc_target,
  output logic [31:0] F_pc
);

  logic [31:0] pc_q, pc_d;

  // Next-PC selection: hold on stall, else redirect, else +4 (wraps)
  always_comb begin
    pc_d = pc_q;
    if (!stall) begin
      if (npc_sel) pc_d = npc_target;
      else         pc_d = pc_q + PC_INC;
    end
  end

  // PC register; reset beats every other control
  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign F_pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Drives the instruction memory address from the PC and captures the
// returned word with its PC one cycle later. Redirects from D only move
// the PC, so the word fetched in the redirect cycle (delay slot) still
// enters D. Optional macro FETCH_ADEL_EN adds the fetch address check:
// an illegal fetch enters D as a nop tagged with ADEL.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter logic [31:0] IM_LAST  = IM_LAST_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        npc_sel,
  input  logic [31:0] npc_target,
  output logic [31:0] F_pc,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic [31:0] D_pc8,
  output logic [4:0]  D_exc
);

  logic [31:0] pc;
  logic [4:0]  fetch_exc;
  logic [31:0] fetch_instr;
  ifid_t       ifid_q, ifid_d;

  f_pc #(
    .RESET_PC (RESET_PC)
  ) u_f_pc (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .npc_sel    (npc_sel),
    .npc_target (npc_target),
    .F_pc       (pc)
  );

  // Memory is always addressed by the current PC, even for a bad fetch
  assign i_inst_addr = pc;
  assign F_pc        = pc;

`ifdef FETCH_ADEL_EN
  // Bad fetch: discard the memory data and tag the slot with ADEL
  always_comb begin
    fetch_exc   = EXC_NONE;
    fetch_instr = i_inst_rdata;
    if (fetch_addr_bad(pc, IM_BASE, IM_LAST)) begin
      fetch_exc   = EXC_ADEL;
      fetch_instr = NOP_WORD;
    end
  end
`else
  // Window parameters only matter when the address check is built in
  logic unused_cfg;
  assign unused_cfg = ^{IM_BASE, IM_LAST};

  // No address check: raw word captured, never an exception
  always_comb begin
    fetch_exc   = EXC_NONE;
    fetch_instr = i_inst_rdata;
  end
`endif

  // IF/ID next state: stall holds (even over flush), flush makes a bubble
  always_comb begin
    ifid_d = ifid_q;
    if (!stall) begin
      ifid_d.pc = pc;
      if (flush) begin
        ifid_d.instr = NOP_WORD;
        ifid_d.exc   = EXC_NONE;
      end else begin
        ifid_d.instr = fetch_instr;
        ifid_d.exc   = fetch_exc;
      end
    end
  end

  // IF/ID register; reset loads a nop tagged with the reset PC
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_q.instr <= NOP_WORD;
      ifid_q.pc    <= RESET_PC;
      ifid_q.exc   <= EXC_NONE;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign D_instr = ifid_q.instr;
  assign D_pc    = ifid_q.pc;
  // Link value derived from the registered PC, valid alongside D_pc
  assign D_pc8   = ifid_q.pc + LINK_OFS;
  assign D_exc   = ifid_q.exc;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed vector table, ADEL corner runs,
// then randomized traffic against a reference model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_inst_addr, i_inst_rdata;
  logic        stall, flush, npc_sel;
  logic [31:0] npc_target;
  logic [31:0] F_pc, D_instr, D_pc, D_pc8;
  logic [4:0]  D_exc;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .i_inst_addr  (i_inst_addr),
    .i_inst_rdata (i_inst_rdata),
    .stall        (stall),
    .flush        (flush),
    .npc_sel      (npc_sel),
    .npc_target   (npc_target),
    .F_pc         (F_pc),
    .D_instr      (D_instr),
    .D_pc         (D_pc),
    .D_pc8        (D_pc8),
    .D_exc        (D_exc)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: fetch PC and the instruction sitting in D
  logic [31:0] m_pc, m_instr, m_dpc;
  logic [4:0]  m_exc;
  bit          m_valid = 0;

  function automatic logic [4:0] m_fetch_exc(input logic [31:0] a);
`ifdef FETCH_ADEL_EN
    if ((a % 4) != 0 || a < 32'h3000 || a > 32'h6FFC) return 5'd4;
`endif
    return 5'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model on the edge
  task automatic step(input bit r, input bit s, input bit f, input bit n,
                      input logic [31:0] t, input logic [31:0] rd);
    reset = r; stall = s; flush = f; npc_sel = n; npc_target = t; i_inst_rdata = rd;
    #1;
    if (m_valid) chk("imem_addr", i_inst_addr, m_pc);
    @(posedge clk);
    if (r) begin
      m_pc = 32'h3000; m_instr = 0; m_dpc = 32'h3000; m_exc = 0; m_valid = 1;
    end else begin
      if (!s) begin
        m_dpc = m_pc;
        if (f) begin
          m_instr = 0; m_exc = 0;
        end else begin
          m_exc   = m_fetch_exc(m_pc);
          m_instr = (m_exc != 0) ? 32'h0 : rd;
        end
      end
      if (!s) m_pc = n ? t : m_pc + 4;
    end
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_fpc"},   F_pc,           m_pc);
    chk({tag, "_instr"}, D_instr,        m_instr);
    chk({tag, "_dpc"},   D_pc,           m_dpc);
    chk({tag, "_dpc8"},  D_pc8,          m_dpc + 32'd8);
    chk({tag, "_exc"},   {27'd0, D_exc}, {27'd0, m_exc});
  endtask

  typedef struct {
    bit          r, s, f, n;
    logic [31:0] tgt, rd;
    logic [31:0] e_fpc, e_instr, e_dpc;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit r, bit s, bit f, bit n, logic [31:0] tgt,
                              logic [31:0] rd, logic [31:0] ef,
                              logic [31:0] ei, logic [31:0] ep);
    vec_t v;
    v.r = r; v.s = s; v.f = f; v.n = n; v.tgt = tgt; v.rd = rd;
    v.e_fpc = ef; v.e_instr = ei; v.e_dpc = ep;
    return v;
  endfunction

  // Reset, redirect to tgt, then fetch once from tgt with known data
  task automatic adel_run(input logic [31:0] tgt, input bit expect_adel);
    logic [4:0]  want_exc;
    logic [31:0] want_instr;
    want_exc   = 5'd0;
    want_instr = 32'hDEAD_BEEF;
`ifdef FETCH_ADEL_EN
    if (expect_adel) begin
      want_exc   = 5'd4;
      want_instr = 32'h0;
    end
`endif
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, tgt, 32'h2001_0001);
    chk("adel_fpc_tgt", F_pc, tgt);
    step(0, 0, 0, 0, 0, 32'hDEAD_BEEF);
    chk("adel_instr", D_instr, want_instr);
    chk("adel_dpc",   D_pc,    tgt);
    chk("adel_exc",   {27'd0, D_exc}, {27'd0, want_exc});
    chk("adel_fpc_next", F_pc, tgt + 32'd4);
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0; npc_sel = 0; npc_target = 0; i_inst_rdata = 0;

    // Directed sequence: r s f n target data -> F_pc D_instr D_pc
    vt.push_back(mk(1,0,0,0, 32'h0,    32'h0,         32'h3000, 32'h0,         32'h3000));
    vt.push_back(mk(1,0,0,0, 32'h0,    32'h0,         32'h3000, 32'h0,         32'h3000));
    vt.push_back(mk(0,0,0,0, 32'h0,    32'h2001_0001, 32'h3004, 32'h2001_0001, 32'h3000));
    vt.push_back(mk(0,0,0,0, 32'h0,    32'h2002_0002, 32'h3008, 32'h2002_0002, 32'h3004));
    vt.push_back(mk(0,0,0,1, 32'h3100, 32'h2003_0003, 32'h3100, 32'h2003_0003, 32'h3008));
    vt.push_back(mk(0,0,0,0, 32'h0,    32'h1111_0000, 32'h3104, 32'h1111_0000, 32'h3100));
    vt.push_back(mk(0,0,0,1, 32'h3010, 32'h1111_0004, 32'h3010, 32'h1111_0004, 32'h3104));
    vt.push_back(mk(0,1,0,0, 32'h0,    32'h3333_0010, 32'h3010, 32'h1111_0004, 32'h3104));
    vt.push_back(mk(0,1,0,0, 32'h0,    32'h3333_0010, 32'h3010, 32'h1111_0004, 32'h3104));
    vt.push_back(mk(0,0,0,0, 32'h0,    32'h3333_0010, 32'h3014, 32'h3333_0010, 32'h3010));
    vt.push_back(mk(0,0,0,0, 32'h0,    32'h3333_0014, 32'h3018, 32'h3333_0014, 32'h3014));
    vt.push_back(mk(0,1,0,1, 32'h3200, 32'h3333_0018, 32'h3018, 32'h3333_0014, 32'h3014));
    vt.push_back(mk(0,0,0,1, 32'h3200, 32'h3333_0018, 32'h3200, 32'h3333_0018, 32'h3018));
    vt.push_back(mk(0,0,1,0, 32'h0,    32'h1234_5678, 32'h3204, 32'h0,         32'h3200));
    vt.push_back(mk(0,0,0,0, 32'h0,    32'h4444_0204, 32'h3208, 32'h4444_0204, 32'h3204));
    vt.push_back(mk(0,1,1,0, 32'h0,    32'h1234_5678, 32'h3208, 32'h4444_0204, 32'h3204));
    vt.push_back(mk(1,1,1,1, 32'h5000, 32'h9999_9999, 32'h3000, 32'h0,         32'h3000));
    vt.push_back(mk(0,0,0,0, 32'h0,    32'h5555_0000, 32'h3004, 32'h5555_0000, 32'h3000));
    vt.push_back(mk(0,0,0,1, 32'hFFFF_FFFC, 32'h5555_0004, 32'hFFFF_FFFC, 32'h5555_0004, 32'h3004));
    vt.push_back(mk(0,1,0,0, 32'h0,    32'h0,         32'hFFFF_FFFC, 32'h5555_0004, 32'h3004));
    vt.push_back(mk(1,0,0,0, 32'h0,    32'h0,         32'h3000, 32'h0,         32'h3000));

    foreach (vt[i]) begin
      step(vt[i].r, vt[i].s, vt[i].f, vt[i].n, vt[i].tgt, vt[i].rd);
      chk($sformatf("vec%0d_fpc", i),   F_pc,    vt[i].e_fpc);
      chk($sformatf("vec%0d_instr", i), D_instr, vt[i].e_instr);
      chk($sformatf("vec%0d_dpc", i),   D_pc,    vt[i].e_dpc);
      chk($sformatf("vec%0d_dpc8", i),  D_pc8,   vt[i].e_dpc + 32'd8);
      chk($sformatf("vec%0d_exc", i),   {27'd0, D_exc}, 32'd0);
    end

    // PC wrap: redirect to the top word, then step past 2^32
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("wrap_fpc", F_pc, 32'h0000_0000);

    // Fetch-window corner runs
    adel_run(32'h0000_3002, 1'b1);
    adel_run(32'h0000_7000, 1'b1);
    adel_run(32'h0000_2FFC, 1'b1);
    adel_run(32'h0000_6FFC, 1'b0);
    adel_run(32'h0000_3000, 1'b0);

    // Randomized traffic against the model
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 400; k++) begin
      bit          r, s, f, n;
      logic [31:0] t;
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 6) == 0);
      n = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 3))
        0:       t = 32'h3000 + 32'($urandom_range(0, 32'hFFF)) * 4;
        1:       t = $urandom;
        2:       t = 32'h6FF0 + 32'($urandom_range(0, 15));
        default: t = 32'h2FF8 + 32'($urandom_range(0, 15));
      endcase
      step(r, s, f, n, t, $urandom);
      chk_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the P6 pipelined MIPS core.
- Holds the PC, drives the external instruction-memory address, and captures the fetched word with its PC.
- Presents the latched instruction to the D stage, where it is decoded into Op/Func/rs/rt/rd/immediate/jal fields.
- Follows delay-slot semantics: the branch or jump target is supplied by the D stage; the delay-slot instruction is never squashed by a redirect.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- IM_BASE, 32'h0000_3000, lowest legal fetch address (used only with the optional feature).
- IM_LAST, 32'h0000_6FFC, highest legal word-aligned fetch address (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_inst_addr  out  32  fetch address to instruction memory; always equals the current F_pc.
- i_inst_rdata  in  32  instruction word; combinational read of i_inst_addr, same cycle.
- stall  in  1  from hazard unit; freezes PC and IF/ID.
- flush  in  1  clears IF/ID to a bubble.
- npc_sel  in  1  from D stage; 1 = take npc_target next.
- npc_target  in  32  branch, j/jal or jr target computed in D.
- F_pc  out  32  current fetch PC.
- D_instr  out  32  latched instruction.
- D_pc  out  32  PC of D_instr.
- D_pc8  out  32  D_pc + 8, the link value for jal/jalr.
- D_exc  out  5  exception code; only driven with the optional feature, otherwise constant 0.

Behaviour:
- On reset (synchronous):
  - F_pc = RESET_PC.
  - D_instr = 32'h0000_0000 (nop).
  - D_pc = RESET_PC.
  - D_pc8 = RESET_PC + 8.
  - D_exc = 0.
  - reset overrides stall, flush and npc_sel in the same cycle.
- Next-PC selection (evaluated each edge when reset = 0):
  - stall = 1: F_pc holds its value.
  - else npc_sel = 1: F_pc <= npc_target.
  - else: F_pc <= F_pc + 4, 32-bit add, wraps modulo 2^32 with no flag.
- IF/ID register (evaluated each edge when reset = 0):
  - stall = 1: D_* hold, regardless of flush (stall has priority).
  - else flush = 1: D_instr <= 0, D_pc <= F_pc, D_exc <= 0.
  - else: D_instr <= i_inst_rdata, D_pc <= F_pc, D_exc <= fetch exception.
- D_pc8 is always D_pc + 8. It may be held as a register or derived combinationally, but must be valid in the same cycle as D_pc.
- Latency: one cycle from i_inst_addr to D_instr.
- A redirect does not affect the instruction captured in the same cycle. That instruction is the delay slot and enters D normally.
- stall and npc_sel asserted together: the redirect is ignored this cycle. The D stage keeps asserting npc_sel while frozen, so the redirect is taken on the first unstalled cycle.
- npc_target is used unmodified, even when misaligned.
- No internal FSM beyond the PC and IF/ID registers; no handshake besides stall/flush.

Optional Feature:
- Macro: FETCH_ADEL_EN.
- Defined:
  - fetch exception = ADEL (5'd4) when F_pc[1:0] != 0, F_pc < IM_BASE, or F_pc > IM_LAST.
  - On ADEL the IF/ID register captures D_instr = 0 (nop) instead of i_inst_rdata, with D_exc = 4 and D_pc = F_pc.
  - i_inst_addr is still driven; its data is discarded.
- Undefined: no range check; D_exc is tied to 0; i_inst_rdata is always captured.

Decomposition:
- constants.v holds:
  - RESET_PC, IM_BASE, IM_LAST defaults.
  - NOP word 32'h0.
  - Exception codes, at least EXC_ADEL = 5'd4 and EXC_NONE = 5'd0.
  - PC increment 4 and link offset 8.
- One natural sub-module: f_pc, containing the PC register and next-PC mux (clk, reset, stall, npc_sel, npc_target -> F_pc).
- The IF/ID register stays in fetch_stage.

Test Plan:
- Reset held 2 cycles, then 3 free cycles with memory returning 0x2001_0001, 0x2002_0002, 0x2003_0003 -> F_pc = 0x3000, 0x3004, 0x3008, 0x300C; D_instr follows one cycle later with D_pc = 0x3000, D_pc8 = 0x3008.
- Redirect: npc_sel = 1, npc_target = 0x3100 while F_pc = 0x3008 -> the word at 0x3008 still reaches D (delay slot); next F_pc = 0x3100, then 0x3104.
- Stall for 2 cycles at F_pc = 0x3010 -> F_pc, D_instr and D_pc unchanged for both cycles; fetch resumes at 0x3014 with no duplicated or lost instruction.
- Stall and npc_sel (0x3200) together for 1 cycle, then npc_sel alone -> the redirect is taken only after the stall releases; F_pc = 0x3200 one edge later.
- flush = 1 with data 0x1234_5678 -> D_instr = 0, D_pc = F_pc; same with stall = 1 -> D holds.
- FETCH_ADEL_EN: npc_target = 0x3002, then a separate run with npc_target = 0x7000 -> D_instr = 0, D_exc = 4 with D_pc = 0x3002 and 0x7000 respectively. Without the macro -> D_exc = 0 and the raw data is captured.
